// File: rtl/saa_tone_bank.sv
// Time-multiplexed square-wave tone bank: one shared decrement/reload datapath sweeps
// all channels after each ce tick, with double-buffered period registers and phase sync.
module saa_tone_bank #(
  parameter int CHANNELS = 6,
  parameter int FREQ_W   = 8,
  parameter int OCT_W    = 3,
  localparam int CNT_W   = FREQ_W + 1 + 2**OCT_W,
  localparam int IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_sys,
  input  logic                rst,
  input  logic                ce,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_ch,
  input  logic [FREQ_W-1:0]   cfg_freq,
  input  logic [OCT_W-1:0]    cfg_oct,
  input  logic                cfg_sync,
  input  logic [CHANNELS-1:0] enable,
  output logic [CHANNELS-1:0] tone,
  output logic [CHANNELS-1:0] pulse,
  output logic                overrun
);

  localparam int SH_W = OCT_W + 1;
  localparam logic [CNT_W-1:0] FMAX = CNT_W'((2**(FREQ_W+1)) - 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(CHANNELS - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  // Reload value R(f,o); half-period in ce ticks is R+1.
  function automatic logic [CNT_W-1:0] reload_f(input logic [FREQ_W-1:0] f,
                                                 input logic [OCT_W-1:0]  o);
    logic [CNT_W-1:0] base;
    logic [SH_W-1:0]  sh;
    base = FMAX - CNT_W'(f);
    sh   = SH_W'(2**OCT_W) - SH_W'(o);
    return (base << sh) - CNT_W'(1);
  endfunction

  state_t              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [FREQ_W-1:0]   freq_q [CHANNELS];
  logic [OCT_W-1:0]    oct_q  [CHANNELS];
  logic [CNT_W-1:0]    cnt_q  [CHANNELS];
  logic [CHANNELS-1:0] tone_q;
  logic [CHANNELS-1:0] pulse_q;
  logic [CHANNELS-1:0] sync_q;
  logic                overrun_q;

  logic [CNT_W-1:0]    reload_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                tone_d;
  logic                pulse_d;
  logic                cfg_hit;

  assign cfg_hit = (32'(cfg_ch) < CHANNELS);

  // Next state of the channel currently on the shared datapath.
  always_comb begin
    reload_d = reload_f(freq_q[idx_q], oct_q[idx_q]);
    cnt_d    = cnt_q[idx_q];
    tone_d   = tone_q[idx_q];
    pulse_d  = 1'b0;
    if (sync_q[idx_q] || !enable[idx_q]) begin
      cnt_d  = reload_d;
      tone_d = 1'b0;
    end else if (cnt_q[idx_q] == '0) begin
      cnt_d   = reload_d;
      tone_d  = ~tone_q[idx_q];
      pulse_d = 1'b1;
    end else begin
      cnt_d = cnt_q[idx_q] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      tone_q    <= '0;
      pulse_q   <= '0;
      sync_q    <= '0;
      overrun_q <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        freq_q[k] <= '0;
        oct_q[k]  <= '0;
        cnt_q[k]  <= reload_f('0, '0);
      end
    end else begin
      pulse_q <= '0;
      case (state_q)
        IDLE: begin
          if (ce) begin
            state_q <= SWEEP;
            idx_q   <= '0;
          end
        end
        SWEEP: begin
          if (ce) overrun_q <= 1'b1;
          cnt_q[idx_q]   <= cnt_d;
          tone_q[idx_q]  <= tone_d;
          pulse_q[idx_q] <= pulse_d;
          sync_q[idx_q]  <= 1'b0;
          if (idx_q == LAST) begin
            state_q <= IDLE;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
      // Shadow writes land after the service read, so a same-slot reload sees the old value.
      if (cfg_hit && cfg_we) begin
        freq_q[cfg_ch] <= cfg_freq;
        oct_q[cfg_ch]  <= cfg_oct;
      end
      if (cfg_hit && cfg_sync) sync_q[cfg_ch] <= 1'b1;
    end
  end

  assign tone    = tone_q;
  assign pulse   = pulse_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_saa_tone_bank.sv
// Directed bench for saa_tone_bank: period table, mid-period rewrite, phase sync,
// overrun drop behaviour and asynchronous reset during a sweep.
module tb_saa_tone_bank;
  localparam int CH = 6;
  localparam int FW = 8;
  localparam int OW = 3;
  localparam int IW = 3;

  logic          clk_sys = 1'b0;
  logic          rst, ce, cfg_we, cfg_sync;
  logic [IW-1:0] cfg_ch;
  logic [FW-1:0] cfg_freq;
  logic [OW-1:0] cfg_oct;
  logic [CH-1:0] enable, tone, pulse;
  logic          overrun;

  always #5 clk_sys = ~clk_sys;

  saa_tone_bank #(.CHANNELS(CH), .FREQ_W(FW), .OCT_W(OW)) dut (
    .clk_sys(clk_sys), .rst(rst), .ce(ce), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_freq(cfg_freq), .cfg_oct(cfg_oct), .cfg_sync(cfg_sync),
    .enable(enable), .tone(tone), .pulse(pulse), .overrun(overrun)
  );

  typedef struct {
    int          ch;
    logic [FW-1:0] f;
    logic [OW-1:0] o;
    int          half;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;
  int cyc_cnt = 0;
  int ce_cyc = 0;
  bit chk_slot = 1'b1;
  int ntog [CH];
  int first_tog [CH];
  int second_tog [CH];
  logic [CH-1:0] tone_prev = '0;
  logic [CH-1:0] pulse_prev = '0;

  always @(posedge clk_sys) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Every pulse must be a lone one-cycle strobe that coincides with a tone flip in its slot.
  always @(negedge clk_sys) begin
    if (pulse != '0) begin
      check("pulse_onehot", $countones(pulse), 1);
      for (int k = 0; k < CH; k++) begin
        if (pulse[k]) begin
          check($sformatf("pulse_width ch%0d", k), int'(pulse_prev[k]), 0);
          check($sformatf("toggle ch%0d", k), int'(tone[k]), int'(!tone_prev[k]));
          if (chk_slot) check($sformatf("pulse_slot ch%0d", k), cyc_cnt - ce_cyc, 2 + k);
          if (ntog[k] == 0) first_tog[k] = tick_cnt;
          else if (ntog[k] == 1) second_tog[k] = tick_cnt;
          ntog[k]++;
        end
      end
    end
    tone_prev  = tone;
    pulse_prev = pulse;
  end

  task automatic do_tick();
    @(negedge clk_sys);
    ce = 1'b1;
    tick_cnt++;
    ce_cyc = cyc_cnt;
    @(negedge clk_sys);
    ce = 1'b0;
    repeat (6) @(negedge clk_sys);
  endtask

  task automatic clear_rec();
    @(posedge clk_sys);
    for (int k = 0; k < CH; k++) begin
      ntog[k] = 0;
      first_tog[k] = 0;
      second_tog[k] = 0;
    end
  endtask

  task automatic settle();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic write_cfg(input int ch, input logic [FW-1:0] f, input logic [OW-1:0] o,
                           input bit sync);
    @(negedge clk_sys);
    cfg_we   = 1'b1;
    cfg_sync = sync;
    cfg_ch   = IW'(ch);
    cfg_freq = f;
    cfg_oct  = o;
    @(negedge clk_sys);
    cfg_we   = 1'b0;
    cfg_sync = 1'b0;
  endtask

  vec_t tbl [CH];

  initial begin
    tbl[0] = '{0, 8'hFF, 3'd7, 512};
    tbl[1] = '{1, 8'h00, 3'd7, 1022};
    tbl[2] = '{2, 8'h80, 3'd5, 3064};
    tbl[3] = '{3, 8'hFE, 3'd7, 514};
    tbl[4] = '{4, 8'hFF, 3'd6, 1024};
    tbl[5] = '{5, 8'hF0, 3'd7, 542};

    rst = 1'b1; ce = 1'b0; cfg_we = 1'b0; cfg_sync = 1'b0;
    cfg_ch = '0; cfg_freq = '0; cfg_oct = '0; enable = '0;
    for (int k = 0; k < CH; k++) begin
      ntog[k] = 0; first_tog[k] = 0; second_tog[k] = 0;
    end
    repeat (3) @(negedge clk_sys);
    check("reset tone", int'(tone), 0);
    check("reset pulse", int'(pulse), 0);
    check("reset overrun", int'(overrun), 0);
    @(negedge clk_sys);
    rst = 1'b0;

    // Load all periods while disabled so every counter starts from its own R.
    for (int i = 0; i < CH; i++) write_cfg(tbl[i].ch, tbl[i].f, tbl[i].o, 1'b0);
    do_tick();
    clear_rec();
    tick_cnt = 0;
    enable = '1;
    repeat (3100) do_tick();
    settle();
    for (int i = 0; i < CH; i++) begin
      int c;
      c = tbl[i].ch;
      check($sformatf("first_toggle ch%0d", c), first_tog[c], tbl[i].half);
      if (2 * tbl[i].half <= 3100)
        check($sformatf("half_period ch%0d", c), second_tog[c] - first_tog[c], tbl[i].half);
      check($sformatf("toggle_count ch%0d", c), ntog[c], 3100 / tbl[i].half);
      check($sformatf("tone_level ch%0d", c), int'(tone[c]), (3100 / tbl[i].half) % 2);
    end
    check("overrun idle", int'(overrun), 0);

    // Rewrite ch0 mid-period: current half keeps 512, the next one is 514.
    clear_rec();
    write_cfg(0, 8'hFE, 3'd7, 1'b0);
    repeat (1000) do_tick();
    settle();
    check("rewrite old half ch0", first_tog[0], 3584);
    check("rewrite new half ch0", second_tog[0], 4098);

    // Phase sync on ch3 while its tone is high.
    check("pre_sync tone ch3", int'(tone[3]), 1);
    clear_rec();
    @(negedge clk_sys);
    cfg_sync = 1'b1;
    cfg_ch = 3'd3;
    @(negedge clk_sys);
    cfg_sync = 1'b0;
    do_tick();
    settle();
    check("sync tone ch3", int'(tone[3]), 0);
    check("sync no_pulse ch3", ntog[3], 0);
    repeat (519) do_tick();
    settle();
    check("sync toggles ch3", ntog[3], 1);
    check("sync first ch3", first_tog[3], 4615);

    // Write and sync together on ch5: the sync reload uses the new period.
    clear_rec();
    write_cfg(5, 8'hFF, 3'd7, 1'b1);
    repeat (480) do_tick();
    settle();
    check("we_sync tone ch5", int'(tone[5]), 0);
    check("we_sync no_toggle ch5", ntog[5], 0);

    // Ticks every 4 clocks: every other one falls inside a sweep and is dropped.
    check("overrun before burst", int'(overrun), 0);
    chk_slot = 1'b0;
    repeat (64) begin
      @(negedge clk_sys);
      ce = 1'b1;
      @(negedge clk_sys);
      ce = 1'b0;
      repeat (2) @(negedge clk_sys);
    end
    repeat (8) @(negedge clk_sys);
    settle();
    check("overrun set", int'(overrun), 1);
    check("burst no_toggle ch5", ntog[5], 0);
    check("burst tone ch5", int'(tone[5]), 0);
    chk_slot = 1'b1;
    do_tick();
    settle();
    check("after burst toggle ch5", ntog[5], 1);
    check("after burst tone ch5", int'(tone[5]), 1);
    check("overrun sticky", int'(overrun), 1);

    // Asynchronous reset in the middle of a sweep.
    @(negedge clk_sys);
    ce = 1'b1;
    @(negedge clk_sys);
    ce = 1'b0;
    @(negedge clk_sys);
    rst = 1'b1;
    #1;
    check("midsweep rst tone", int'(tone), 0);
    check("midsweep rst pulse", int'(pulse), 0);
    check("midsweep rst overrun", int'(overrun), 0);
    enable = '0;
    @(negedge clk_sys);
    rst = 1'b0;
    clear_rec();
    repeat (4) do_tick();
    settle();
    check("disabled tone", int'(tone), 0);
    check("disabled toggles", ntog[0] + ntog[1] + ntog[2] + ntog[3] + ntog[4] + ntog[5], 0);
    check("disabled overrun", int'(overrun), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
